// File: rtl/alu.sv
// alu: registered two's-complement add / subtract / pass-through unit used by
// the CORDIC vectoring stages. One-cycle latency, a new operation every cycle.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high (clears every output)
//   in_valid       A/B/ALU_operation are valid this cycle
//   ALU_operation  0=ADD, 1=SUB, 2=NOP, 3=reserved (behaves as NOP)
//   A, B           signed operands, WORD_WIDTH bits
//   ALU_out        registered result (wraps modulo 2^WORD_WIDTH)
//   out_valid      ALU_out and the flags carry a new result
//   overflow       signed overflow of the registered result
//   zero           registered result == 0
//   negative       registered result MSB
module alu #(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            ALU_operation,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  output logic [WORD_WIDTH-1:0] ALU_out,
  output logic                  out_valid,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative
);

  localparam int unsigned MSB = WORD_WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_NOP = 2'd2,
    OP_RSV = 2'd3
  } alu_op_e;

  alu_op_e               op;
  logic [WORD_WIDTH-1:0] result;
  logic                  result_ovf;

  assign op = alu_op_e'(ALU_operation);

  always_comb begin
    result     = A;
    result_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        result     = A + B;
        // Like-signed operands producing an opposite-signed sum.
        result_ovf = (A[MSB] == B[MSB]) && (result[MSB] != A[MSB]);
      end
      OP_SUB: begin
        result     = A - B;
        // Unlike-signed operands whose difference leaves A's sign.
        result_ovf = (A[MSB] != B[MSB]) && (result[MSB] != A[MSB]);
      end
      default: begin
        result     = A;
        result_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_out   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Result and flags hold while no operation is presented.
      if (in_valid) begin
        ALU_out  <= result;
        overflow <= result_ovf;
        zero     <= (result == '0);
        negative <= result[MSB];
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed plus randomized bench for alu (WORD_WIDTH=16). Expected
// values come from an integer-arithmetic reference model.
module tb_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   ALU_operation;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] ALU_out;
  logic         out_valid;
  logic         overflow;
  logic         zero;
  logic         negative;

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs must show after the latest edge.
  logic [W-1:0] m_out;
  logic         m_valid, m_ovf, m_zero, m_neg;

  alu #(.WORD_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .ALU_operation(ALU_operation),
    .A            (A),
    .B            (B),
    .ALU_out      (ALU_out),
    .out_valid    (out_valid),
    .overflow     (overflow),
    .zero         (zero),
    .negative     (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"}, 32'(ALU_out), 32'(m_out));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".zero"}, 32'(zero), 32'(m_zero));
    chk({tag, ".neg"}, 32'(negative), 32'(m_neg));
  endtask

  // Model one clock edge using plain signed integer arithmetic.
  task automatic model_edge(input logic r, input logic v, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, res;
    logic [31:0] res_bits;
    if (r) begin
      m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_neg = 1'b0;
      return;
    end
    m_valid = v;
    if (!v) return;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    res = sa + sb;
      2'd1:    res = sa - sb;
      default: res = sa;
    endcase
    res_bits = res;
    m_out  = res_bits[W-1:0];
    m_ovf  = (res > 32767) || (res < -32768);
    m_zero = (m_out == 0);
    m_neg  = m_out[W-1];
  endtask

  task automatic step(input string tag, input logic r, input logic v, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst = r; in_valid = v; ALU_operation = op; A = a; B = b;
    @(posedge clk);
    model_edge(r, v, op, a, b);
    #1;
    check_all(tag);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; ALU_operation = 2'd2; A = '0; B = '0;

    // Reset for two cycles, then release with nothing issued.
    step("rst0", 1'b1, 1'b0, 2'd0, 16'd5, 16'd6);
    step("rst1", 1'b1, 1'b1, 2'd0, 16'd5, 16'd6);
    chk("rst_out_const", 32'(ALU_out), 32'd0);
    step("idle", 1'b0, 1'b0, 2'd0, 16'd9, 16'd9);
    chk("idle_valid_const", 32'(out_valid), 32'd0);

    // Back-to-back ADD.
    step("add48", 1'b0, 1'b1, 2'd0, 16'd16, 16'd32);
    chk("add48_const", 32'(ALU_out), 32'd48);
    step("add39", 1'b0, 1'b1, 2'd0, 16'd21, 16'd18);
    chk("add39_const", 32'(ALU_out), 32'd39);
    chk("add39_valid_const", 32'(out_valid), 32'd1);

    // Pass-through, including reserved opcode.
    step("nop_ffff", 1'b0, 1'b1, 2'd2, 16'hFFFF, 16'd1);
    chk("nop_ffff_neg_const", 32'(negative), 32'd1);
    step("nop128", 1'b0, 1'b1, 2'd2, 16'd128, 16'd17);
    chk("nop128_const", 32'(ALU_out), 32'd128);
    step("rsv", 1'b0, 1'b1, 2'd3, 16'h7FFF, 16'd1);

    // SUB cases.
    step("sub0", 1'b0, 1'b1, 2'd1, 16'd20, 16'd20);
    chk("sub0_zero_const", 32'(zero), 32'd1);
    step("sub47", 1'b0, 1'b1, 2'd1, 16'd72, 16'd25);
    step("sub_neg", 1'b0, 1'b1, 2'd1, 16'd45, 16'd90);
    chk("sub_neg_const", 32'(ALU_out), 32'h0000FFD3);

    // Overflow boundaries.
    step("add_ovf", 1'b0, 1'b1, 2'd0, 16'h7FFF, 16'h0001);
    chk("add_ovf_const", 32'(overflow), 32'd1);
    step("sub_ovf", 1'b0, 1'b1, 2'd1, 16'h8000, 16'h0001);
    chk("sub_ovf_const", 32'(ALU_out), 32'h00007FFF);
    step("sub_minB", 1'b0, 1'b1, 2'd1, 16'd0, 16'h8000);
    step("sub_minB2", 1'b0, 1'b1, 2'd1, 16'hFFFF, 16'h8000);

    // Reset overrides an operation in flight.
    step("pre_rst", 1'b0, 1'b1, 2'd0, 16'd100, 16'd23);
    step("mid_rst", 1'b1, 1'b1, 2'd0, 16'd1, 16'd2);
    step("post_rst", 1'b0, 1'b1, 2'd1, 16'd3, 16'd10);

    // Hold while in_valid is low.
    for (int i = 0; i < 3; i++)
      step("hold", 1'b0, 1'b0, 2'($urandom_range(0, 3)), pick(), pick());
    chk("hold_out_const", 32'(ALU_out), 32'h0000FFF9);

    // Randomized traffic, occasional idle cycles and resets.
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), pick(), pick());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
